mmio_gpio_bank: RTL
===================

Name: mmio_gpio_bank

Overview:
Parametrised memory-mapped GPIO bank for the CPU data bus. It provides three functions:
- Synchronised switch inputs.
- Debounced buttons with sticky rising-edge status and a masked interrupt line.
- A configurable number of read/write output registers that drive LEDs or the tube driver.

It sits beside the VGA text buffer in the MMIO address space. The top level muxes read_data using the hit output.

Parameters:
BASE_ADDR, 16'h0000, MMIO window base; window is 256 bytes, decoded on addr[15:8] == BASE_ADDR[15:8].
SW_WIDTH, 24, number of switch inputs (1..32).
BTN_WIDTH, 5, number of button inputs (1..32).
NUM_OUT, 4, number of R/W output registers (1..56).
OUT_WIDTH, 32, width of each output register (1..32).
DEBOUNCE_CYCLES, 16, stable data_clk cycles required before the debounced level changes (>=2).
ID_VALUE, 32'h1234_ABCD, constant returned at offset 0x00.

Ports:
data_clk  input  1  bus/system clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
addr  input  32  byte address; only addr[15:2] decoded, addr[1:0] ignored.
write_data  input  32  store data.
wen  input  1  store strobe, sampled on posedge data_clk.
read_data  output  32  combinational read of the addressed register; 0 when not hit or unmapped.
hit  output  1  combinational: addr inside this block's window.
switches  input  SW_WIDTH  raw asynchronous switch levels.
buttons  input  BTN_WIDTH  raw asynchronous button levels.
out_regs  output  NUM_OUT*OUT_WIDTH  flattened output registers; register i at bits [i*OUT_WIDTH +: OUT_WIDTH].
out_nonzero  output  NUM_OUT  bit i = (output register i != 0).
irq  output  1  registered; |(btn_status & btn_mask).

Behaviour:
Address map (offset = addr[7:0]):
- 0x00 ID: RO, ID_VALUE.
- 0x04 SW: RO, synchronised switches, zero-extended.
- 0x08 BTN_LEVEL: RO, debounced levels, zero-extended.
- 0x0C BTN_STATUS: sticky rising-edge flags; write-1-to-clear.
- 0x10 BTN_MASK: RW; only the low BTN_WIDTH bits are stored.
- 0x20 + 4*i OUT[i], i < NUM_OUT: RW; write_data[OUT_WIDTH-1:0] is stored; read zero-extended.
- All other offsets read 0; writes to them are ignored.

Write rules:
- A write takes effect only when wen && hit && the offset is RW/W1C, on posedge data_clk.
- Writes to RO offsets are ignored.

Read timing:
- Reads are combinational on addr (zero latency).
- A read in the same cycle as a write returns the old value.

Synchroniser:
- 2-flop synchroniser on every switch and button bit.
- SW read reflects a raw change 2 cycles later.

Debounce, per button, using a counter of width $clog2(DEBOUNCE_CYCLES):
- If sync != level: counter increments. When counter == DEBOUNCE_CYCLES-1, level <= sync and counter <= 0.
- If sync == level: counter <= 0. A glitch shorter than DEBOUNCE_CYCLES never toggles the level.
- Latency from raw edge to level change = 2 + DEBOUNCE_CYCLES cycles.

Edge status:
- A debounced 0->1 transition sets btn_status[b] in the cycle the level rises.
- Falling edges do not set status.
- Hardware set and W1C of the same bit in the same cycle: the set wins (bit stays 1).
- W1C of a bit with no pending set clears it; writing 0 bits has no effect.
- Mask does not gate capture, only irq.

irq:
- Registered one cycle after the status/mask state.
- Deasserts the cycle after a clear or mask removal.

Reset (asynchronous, any time):
- Sync flops, levels, counters, btn_status, btn_mask, out_regs and irq are all set to 0.
- A debounce in progress is discarded.
- out_nonzero = 0.

Decomposition:
- Package mmio_gpio_pkg: offset constants (OFF_ID, OFF_SW, OFF_BTN_LEVEL, OFF_BTN_STATUS, OFF_BTN_MASK, OFF_OUT_BASE) and a function that decodes an offset into an output-register index plus a valid flag.
- One sub-module, gpio_debounce: a single-bit synchroniser plus debounce counter with an edge pulse output. It is parametrised by DEBOUNCE_CYCLES and instantiated BTN_WIDTH times in a generate loop.

Test Plan:
1. Reset, then read 0x00, 0x04 (switches=24'hA5A5A5 held), 0x24 -> 32'h1234_ABCD, 32'h00A5A5A5 (valid from the 3rd cycle), 0.
2. Write 32'hDEAD_BEEF to 0x28, then 0 to 0x28 -> out_regs[2] = DEADBEEF and out_nonzero = 4'b0100; then out_nonzero = 0. Write to 0x04 -> SW readback unchanged; read 0x1C -> 0.
3. buttons[1] high for 10 cycles then low (DEBOUNCE_CYCLES=16) -> BTN_LEVEL stays 0 and BTN_STATUS stays 0.
4. buttons[1] held high -> BTN_LEVEL bit1 = 1 exactly 18 cycles after the raw edge; BTN_STATUS = 0x2. With BTN_MASK = 0x2, irq = 1 one cycle later. Write 0x2 to 0x0C -> status 0, irq 0 the next cycle.
5. W1C of bit 0 issued in the same cycle the bit-0 debounced level rises -> BTN_STATUS bit0 remains 1.
6. Assert rst asynchronously mid-debounce, with out_regs and mask nonzero -> all outputs 0 immediately. After release, the held button needs a full 18 cycles to re-register.

Source files
------------

// File: rtl/mmio_gpio_pkg.sv
// rtl/mmio_gpio_pkg.sv - shared constants and decode helper for the MMIO GPIO bank
// Purpose: register offsets within the 256-byte window, plus a helper that
//          maps a word offset onto an output-register index.
// Ports:   none (package).
package mmio_gpio_pkg;

  localparam logic [7:0] OFF_ID         = 8'h00;
  localparam logic [7:0] OFF_SW         = 8'h04;
  localparam logic [7:0] OFF_BTN_LEVEL  = 8'h08;
  localparam logic [7:0] OFF_BTN_STATUS = 8'h0C;
  localparam logic [7:0] OFF_BTN_MASK   = 8'h10;
  localparam logic [7:0] OFF_OUT_BASE   = 8'h20;

  // Word (addr[7:2]) form of OFF_OUT_BASE; the output registers fill the
  // remaining 56 words of the window.
  localparam logic [5:0] OUT_BASE_WORD  = 6'h08;

  typedef struct packed {
    logic       valid;
    logic [5:0] idx;
  } out_sel_t;

  // Decode a word offset into an output-register index. valid is set only
  // when the word lies at or above the OUT base and below num_out.
  function automatic out_sel_t decode_out(input logic [5:0] word, input int num_out);
    out_sel_t s;
    s.valid = 1'b0;
    s.idx   = '0;
    if (word >= OUT_BASE_WORD) begin
      s.idx   = word - OUT_BASE_WORD;
      s.valid = (int'(s.idx) < num_out);
    end
    return s;
  endfunction

endpackage

// File: rtl/mmio_gpio_bank_if.sv
// rtl/mmio_gpio_bank_if.sv - CPU data-bus MMIO interface for the GPIO bank
// Purpose: groups the bus address/data/strobe and the combinational
//          read_data/hit response.
// Signals: addr (byte address), write_data, wen (store strobe),
//          read_data (read response), hit (address inside window).
// Modports: master drives the request, slave answers it.
interface mmio_gpio_bank_if;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        wen;
  logic [31:0] read_data;
  logic        hit;

  modport master (output addr, output write_data, output wen,
                  input  read_data, input hit);
  modport slave  (input  addr, input write_data, input wen,
                  output read_data, output hit);
endinterface

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - single-bit 2-flop synchroniser with debounce counter
// Purpose: brings one raw asynchronous button into data_clk and only moves
//          the debounced level after DEBOUNCE_CYCLES stable cycles.
// Ports:   data_clk, rst (async, active-high), raw_i (raw level),
//          level_o (debounced level), rise_o (high in the cycle whose
//          clock edge raises level_o).
module gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic data_clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int                 CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised input agrees with the level restarts the
  // count, so only an uninterrupted disagreement can flip the level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_o  = 1'b0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q;
        rise_o  = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge data_clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= raw_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/mmio_gpio_bank.sv
// rtl/mmio_gpio_bank.sv - memory-mapped GPIO bank: switches, buttons, output regs
// Purpose: 256-byte MMIO window with ID, synchronised switches, debounced
//          buttons (sticky rising-edge status, mask, irq) and NUM_OUT R/W
//          output registers.
// Ports:   data_clk, rst (async, active-high), bus (slave: addr, write_data,
//          wen, read_data, hit), switches, buttons, out_regs (flattened),
//          out_nonzero (per-register non-zero flag), irq (registered).
module mmio_gpio_bank
  import mmio_gpio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR       = 16'h0000,
  parameter int          SW_WIDTH        = 24,
  parameter int          BTN_WIDTH       = 5,
  parameter int          NUM_OUT         = 4,
  parameter int          OUT_WIDTH       = 32,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] ID_VALUE        = 32'h1234_ABCD
) (
  input  logic                         data_clk,
  input  logic                         rst,
  mmio_gpio_bank_if.slave              bus,
  input  logic [SW_WIDTH-1:0]          switches,
  input  logic [BTN_WIDTH-1:0]         buttons,
  output logic [NUM_OUT*OUT_WIDTH-1:0] out_regs,
  output logic [NUM_OUT-1:0]           out_nonzero,
  output logic                         irq
);

  logic [SW_WIDTH-1:0]  sw_meta_q, sw_q;
  logic [BTN_WIDTH-1:0] btn_level, btn_rise;
  logic [BTN_WIDTH-1:0] status_q, status_d;
  logic [BTN_WIDTH-1:0] mask_q, mask_d;
  logic [BTN_WIDTH-1:0] w1c;
  logic                 irq_q, irq_d;
  logic [OUT_WIDTH-1:0] out_q [NUM_OUT];
  logic [OUT_WIDTH-1:0] out_d [NUM_OUT];

  logic [5:0]  word;
  logic [7:0]  off;
  logic        wr_en;
  out_sel_t    osel;
  logic [31:0] rdata;

  // Address bits outside the decoded range are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.addr[31:16], bus.addr[1:0], bus.write_data};

  assign word     = bus.addr[7:2];
  assign off      = {word, 2'b00};
  assign bus.hit  = (bus.addr[15:8] == BASE_ADDR[15:8]);
  assign wr_en    = bus.wen && bus.hit;
  assign osel     = decode_out(word, NUM_OUT);

  for (genvar b = 0; b < BTN_WIDTH; b++) begin : g_btn
    gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .data_clk (data_clk),
      .rst      (rst),
      .raw_i    (buttons[b]),
      .level_o  (btn_level[b]),
      .rise_o   (btn_rise[b])
    );
  end

  // Read mux: purely combinational, so a same-cycle write still shows the
  // pre-edge value.
  always_comb begin
    rdata = '0;
    if (bus.hit) begin
      case (off)
        OFF_ID:         rdata = ID_VALUE;
        OFF_SW:         rdata[SW_WIDTH-1:0]  = sw_q;
        OFF_BTN_LEVEL:  rdata[BTN_WIDTH-1:0] = btn_level;
        OFF_BTN_STATUS: rdata[BTN_WIDTH-1:0] = status_q;
        OFF_BTN_MASK:   rdata[BTN_WIDTH-1:0] = mask_q;
        default: begin
          for (int i = 0; i < NUM_OUT; i++) begin
            if (osel.valid && osel.idx == 6'(i)) rdata[OUT_WIDTH-1:0] = out_q[i];
          end
        end
      endcase
    end
  end

  assign bus.read_data = rdata;

  always_comb begin
    mask_d = mask_q;
    if (wr_en && off == OFF_BTN_MASK) mask_d = bus.write_data[BTN_WIDTH-1:0];

    w1c = '0;
    if (wr_en && off == OFF_BTN_STATUS) w1c = bus.write_data[BTN_WIDTH-1:0];
    // OR-ing the rise pulse in after the clear lets a same-cycle set win.
    status_d = (status_q & ~w1c) | btn_rise;

    irq_d = |(status_q & mask_q);

    for (int i = 0; i < NUM_OUT; i++) begin
      out_d[i] = out_q[i];
      if (wr_en && osel.valid && osel.idx == 6'(i)) out_d[i] = bus.write_data[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge data_clk or posedge rst) begin
    if (rst) begin
      sw_meta_q <= '0;
      sw_q      <= '0;
      status_q  <= '0;
      mask_q    <= '0;
      irq_q     <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
    end else begin
      sw_meta_q <= switches;
      sw_q      <= sw_meta_q;
      status_q  <= status_d;
      mask_q    <= mask_d;
      irq_q     <= irq_d;
      for (int i = 0; i < NUM_OUT; i++) out_q[i] <= out_d[i];
    end
  end

  assign irq = irq_q;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_regs[g*OUT_WIDTH +: OUT_WIDTH] = out_q[g];
    assign out_nonzero[g]                     = |out_q[g];
  end

endmodule
